insn_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of insn_decoder. Prefetches words from

---
 rtl/insn_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_insn_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch_unit.sv
// insn_fetch_unit: prefetching instruction fetch stage feeding insn_decoder.
// Optional macro IFU_BYPASS_EN forwards ack data straight to the decoder.
module insn_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pcincr,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0] fifo_addr [DEPTH];
  logic [31:0] fifo_insn [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0] count;
  logic [AW:0] cnt_after_pop;
  logic [31:0] fptr;

  logic [31:0] head_addr;
  logic [31:0] head_insn;
  logic fifo_nz;
  logic hit;
  logic byp;
  logic redirect;
  logic pop;
  logic push;
  logic issue;

  assign head_addr = fifo_addr[rd_ptr];
  assign head_insn = fifo_insn[rd_ptr];
  assign fifo_nz   = (count != '0);
  assign hit       = fifo_nz && (head_addr == pc);

`ifdef IFU_BYPASS_EN
  assign byp = !fifo_nz && (state == REQ) &&
               imem_ack && (imem_addr == pc);
`else
  assign byp = 1'b0;
`endif

  assign redirect =
    (fifo_nz && (head_addr != pc)) ||
    (!fifo_nz && (state != REQ) && (fptr != pc)) ||
    (!fifo_nz && (state == REQ) && (imem_addr != pc));

  assign pop  = hit && pcincr && !redirect;
  assign push = (state == REQ) && imem_ack &&
                !redirect && !(byp && pcincr);

  assign cnt_after_pop = count - (AW+1)'(pop);
  assign issue = (state == IDLE) && !redirect &&
                 (cnt_after_pop < FULL);

  // Decoder word: FIFO head when it matches pc, else ack bypass or NOP.
  always_comb begin
    word       = NOP_WORD;
    word_valid = 1'b0;
    unique case (1'b1)
      hit: begin
        word       = head_insn;
        word_valid = 1'b1;
      end
      byp: begin
        word       = imem_rdata;
        word_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Request FSM next state; a redirect mid-request turns it into a drop.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (issue) state_nx = REQ;
      REQ: begin
        if (imem_ack)      state_nx = IDLE;
        else if (redirect) state_nx = DROP;
      end
      DROP: if (imem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM, FIFO pointers, fetch pointer and memory request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fptr      <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state <= state_nx;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        fptr   <= pc;
      end else begin
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (issue) fptr   <= fptr + PC_STEP;
        count <= count + (AW+1)'(push)
                       - (AW+1)'(pop);
      end
      if (issue) begin
        imem_req  <= 1'b1;
        imem_addr <= fptr;
      end else if ((state != IDLE) && imem_ack) begin
        imem_req <= 1'b0;
      end
    end
  end

  // FIFO storage, tagged with the address it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= imem_addr;
      fifo_insn[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_insn_fetch_unit.sv
// tb_insn_fetch_unit: randomized bench for insn_fetch_unit
// against a queue-level reference model of the fetch stage.
module tb_insn_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] NOP    = 32'h0;
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        pcincr = 1'b0;
  logic [31:0] word;
  logic        word_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;

  insn_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pcincr     (pcincr),
    .word       (word),
    .word_valid (word_valid),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_fptr;
  logic [31:0] m_addr;
  bit          m_req;
  bit          m_drop;
  logic [31:0] e_word;
  bit          e_valid;
  bit          e_byp;
  bit          e_consume;
  logic [31:0] seen[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_fptr = RST_PC;
    m_addr = '0;
    m_req  = 1'b0;
    m_drop = 1'b0;
  endtask

  function automatic bit m_live();
    return m_req && !m_drop;
  endfunction

  // Expected outputs of the current cycle, then compare.
  task automatic sample();
    #3;
    e_byp = 1'b0;
    if (BYP)
      e_byp = (q.size() == 0) && m_live() &&
              imem_ack && (m_addr == pc);
    if (q.size() != 0 && q[0].a == pc) begin
      e_word  = q[0].d;
      e_valid = 1'b1;
    end else if (e_byp) begin
      e_word  = imem_rdata;
      e_valid = 1'b1;
    end else begin
      e_word  = NOP;
      e_valid = 1'b0;
    end
    e_consume = e_valid && pcincr;
    if (rst) begin
      chk("word", word, e_word);
      chk("word_valid", 32'(word_valid), 32'(e_valid));
      chk("imem_req", 32'(imem_req), 32'(m_req));
      if (m_req) chk("imem_addr", imem_addr, m_addr);
    end
  endtask

  // Model state update over the clock edge; decoder pc follows.
  task automatic advance();
    bit redir;
    int left;
    if (q.size() != 0)  redir = (q[0].a != pc);
    else if (m_live())  redir = (m_addr != pc);
    else                redir = (m_fptr != pc);
    if (!rst) begin
      m_reset();
    end else if (redir) begin
      q.delete();
      m_fptr = pc;
      if (m_req) begin
        if (imem_ack) begin
          m_req  = 1'b0;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
    end else begin
      if (q.size() != 0 && q[0].a == pc && pcincr)
        void'(q.pop_front());
      if (m_req) begin
        if (imem_ack) begin
          if (!m_drop && !(e_byp && pcincr))
            q.push_back('{a: m_addr, d: imem_rdata});
          m_req  = 1'b0;
          m_drop = 1'b0;
        end
      end else begin
        left = q.size();
        if (left < DEPTH) begin
          m_req  = 1'b1;
          m_addr = m_fptr;
          m_fptr = m_fptr + 32'd1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst && e_consume) pc = pc + 32'd1;
  endtask

  task automatic drive_mem(int ack_pct, int junk_pct);
    if (m_req) begin
      imem_ack   = ($urandom_range(0, 99) < ack_pct);
      imem_rdata = imem_ack ? m_addr + 32'hA000 : $urandom;
    end else begin
      imem_ack   = ($urandom_range(0, 99) < junk_pct);
      imem_rdata = $urandom;
    end
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    m_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    pcincr     = 1'b0;
    pc         = RST_PC;
    #1;
    chk("rst_async_req", 32'(imem_req), 32'd0);
    chk("rst_async_valid", 32'(word_valid), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int nreq;
    bit found;
    bit stable;
    m_reset();
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    sample();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_word", word, NOP);
    chk("rst_valid", 32'(word_valid), 32'd0);
    advance();

    imem_ack = 1'b0;
    sample();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RST_PC);
    advance();

    pcincr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_mem(100, 0);
      sample();
      if (i == 0)
        chk("ack_cycle_valid", 32'(word_valid), 32'(BYP));
      if (word_valid) seen.push_back(word);
      advance();
    end
    chk("seq_count", 32'(seen.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++)
      chk("seq_word",
          (i < seen.size()) ? seen[i] : 32'hFFFF_FFFF,
          32'hA000 + 32'(i));

    do_reset();
    nreq   = 0;
    pcincr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_mem(100, 0);
      sample();
      if (imem_req && imem_ack) nreq++;
      advance();
    end
    chk("full_reqs", 32'(nreq), 32'd4);
    imem_ack = 1'b0;
    pcincr   = 1'b1;
    sample();
    chk("full_idle", 32'(imem_req), 32'd0);
    chk("full_head", word, 32'hA000);
    advance();
    pcincr = 1'b0;
    sample();
    chk("refill_req", 32'(imem_req), 32'd1);
    chk("refill_addr", imem_addr, 32'd4);
    advance();

    pc = 32'h40;
    sample();
    chk("redir_valid", 32'(word_valid), 32'd0);
    advance();
    imem_ack   = 1'b1;
    imem_rdata = 32'hA004;
    sample();
    advance();
    imem_ack = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      sample();
      if (imem_req) begin
        chk("redir_addr", imem_addr, 32'h40);
        found = 1'b1;
      end
      advance();
    end
    chk("redir_found", 32'(found), 32'd1);

    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample();
      stable &= imem_req && (imem_addr == 32'h40) &&
                !word_valid && (word == NOP);
      advance();
    end
    chk("stall_hold", 32'(stable), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hA040;
    sample();
    chk("stall_ack_valid", 32'(word_valid), 32'(BYP));
    advance();
    imem_ack = 1'b0;
    sample();
    chk("stall_word_valid", 32'(word_valid), 32'd1);
    chk("stall_word", word, 32'hA040);
    advance();

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 99) < 3) begin
        case ($urandom_range(0, 3))
          0:       pc = 32'h40;
          1:       pc = 32'($urandom_range(0, 255));
          2:       pc = 32'hFFFF_FFFE;
          default: pc = pc + 32'd2;
        endcase
      end
      pcincr = ($urandom_range(0, 99) < 70);
      drive_mem(35, 10);
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
